// File: rtl/text_buffer_writer.sv
// Host write engine for the HDMI console char/attr text RAM: cursor-addressed
// character writes, hardware line scrolling via a row offset, and full-buffer clear.
module text_buffer_writer #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int PHYS_ROWS = 64
) (
    input  logic        i_clock_core,
    input  logic        i_reset_n,
    input  logic        i_host_we,
    input  logic [2:0]  i_host_addr,
    input  logic [7:0]  i_host_wdata,
    output logic        o_busy,
    output logic        o_ram_we,
    output logic [12:0] o_ram_waddr,
    output logic [7:0]  o_ram_wchar,
    output logic [7:0]  o_ram_wattr,
    output logic [7:0]  o_row_offset
);

    // state  | meaning
    // IDLE   | accepting host register writes, BUSY low
    // SCROLL | blanking the row about to scroll into view, then bumping the offset
    // CLEAR  | blanking every physical row, then homing cursor and offset
    typedef enum logic [1:0] {ST_IDLE, ST_SCROLL, ST_CLEAR} state_t;

    localparam logic [7:0] L_COLS8    = 8'(COLS);
    localparam logic [7:0] L_ROWS8    = 8'(ROWS);
    localparam logic [6:0] L_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] L_LAST_ROW = 5'(ROWS - 1);
    localparam logic [6:0] L_END_COL  = 7'(COLS);
    localparam logic [6:0] L_END_ROW  = 7'(PHYS_ROWS);
    localparam logic [5:0] L_ROWS6    = 6'(ROWS);
    localparam logic [7:0] L_BLANK    = 8'h20;

    state_t      r_state, w_state_nxt;
    logic [6:0]  r_col, w_col_nxt;
    logic [4:0]  r_row, w_row_nxt;
    logic [7:0]  r_attr, w_attr_nxt;
    logic [5:0]  r_offset, w_offset_nxt;
    logic [6:0]  r_cnt_col, w_cnt_col_nxt;
    logic [6:0]  r_cnt_row, w_cnt_row_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_we, w_we_nxt;
    logic [12:0] r_waddr, w_waddr_nxt;
    logic [7:0]  r_wchar, w_wchar_nxt;
    logic [7:0]  r_wattr, w_wattr_nxt;

    logic [5:0]  w_phys_row;
    logic [5:0]  w_scroll_row;
    logic        w_start_scroll;
    logic        w_start_clear;

    assign w_phys_row   = {1'b0, r_row} + r_offset;
    // Row just below the visible window; wraps naturally in 6 bits.
    assign w_scroll_row = r_offset + L_ROWS6;

    always_comb begin
        w_state_nxt    = r_state;
        w_col_nxt      = r_col;
        w_row_nxt      = r_row;
        w_attr_nxt     = r_attr;
        w_offset_nxt   = r_offset;
        w_cnt_col_nxt  = r_cnt_col;
        w_cnt_row_nxt  = r_cnt_row;
        w_busy_nxt     = r_busy;
        w_we_nxt       = 1'b0;
        w_waddr_nxt    = r_waddr;
        w_wchar_nxt    = r_wchar;
        w_wattr_nxt    = r_wattr;
        w_start_scroll = 1'b0;
        w_start_clear  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_host_we) begin
                    case (i_host_addr)
                        3'd0: w_col_nxt = (i_host_wdata < L_COLS8) ? i_host_wdata[6:0] : 7'd0;
                        3'd1: w_row_nxt = (i_host_wdata < L_ROWS8) ? i_host_wdata[4:0] : L_LAST_ROW;
                        3'd2: w_attr_nxt = i_host_wdata;
                        3'd3: begin
                            w_we_nxt    = 1'b1;
                            w_waddr_nxt = {w_phys_row, r_col};
                            w_wchar_nxt = i_host_wdata;
                            w_wattr_nxt = r_attr;
                            if (r_col != L_LAST_COL) begin
                                w_col_nxt = r_col + 7'd1;
                            end else begin
                                w_col_nxt = 7'd0;
                                if (r_row != L_LAST_ROW) w_row_nxt = r_row + 5'd1;
                                else                     w_start_scroll = 1'b1;
                            end
                        end
                        3'd4: begin
                            if (i_host_wdata[0]) begin
                                w_start_clear = 1'b1;
                            end else if (i_host_wdata[1]) begin
                                w_col_nxt = 7'd0;
                                if (r_row != L_LAST_ROW) w_row_nxt = r_row + 5'd1;
                                else                     w_start_scroll = 1'b1;
                            end
                        end
                        3'd5: w_offset_nxt = i_host_wdata[5:0];
                        default: ;
                    endcase
                end
                if (w_start_clear) begin
                    w_state_nxt   = ST_CLEAR;
                    w_busy_nxt    = 1'b1;
                    w_cnt_col_nxt = 7'd0;
                    w_cnt_row_nxt = 7'd0;
                end else if (w_start_scroll) begin
                    w_state_nxt   = ST_SCROLL;
                    w_busy_nxt    = 1'b1;
                    w_cnt_col_nxt = 7'd0;
                end
            end

            ST_SCROLL: begin
                if (r_cnt_col == L_END_COL) begin
                    // Offset moves only once the new row is fully blank.
                    w_offset_nxt = r_offset + 6'd1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_we_nxt      = 1'b1;
                    w_waddr_nxt   = {w_scroll_row, r_cnt_col};
                    w_wchar_nxt   = L_BLANK;
                    w_wattr_nxt   = r_attr;
                    w_cnt_col_nxt = r_cnt_col + 7'd1;
                end
            end

            ST_CLEAR: begin
                if (r_cnt_row == L_END_ROW) begin
                    w_offset_nxt = 6'd0;
                    w_col_nxt    = 7'd0;
                    w_row_nxt    = 5'd0;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = {r_cnt_row[5:0], r_cnt_col};
                    w_wchar_nxt = L_BLANK;
                    w_wattr_nxt = r_attr;
                    if (r_cnt_col == L_LAST_COL) begin
                        w_cnt_col_nxt = 7'd0;
                        w_cnt_row_nxt = r_cnt_row + 7'd1;
                    end else begin
                        w_cnt_col_nxt = r_cnt_col + 7'd1;
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock_core or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_col     <= 7'd0;
            r_row     <= 5'd0;
            r_attr    <= 8'h0F;
            r_offset  <= 6'd0;
            r_cnt_col <= 7'd0;
            r_cnt_row <= 7'd0;
            r_busy    <= 1'b0;
            r_we      <= 1'b0;
            r_waddr   <= 13'd0;
            r_wchar   <= 8'd0;
            r_wattr   <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_col     <= w_col_nxt;
            r_row     <= w_row_nxt;
            r_attr    <= w_attr_nxt;
            r_offset  <= w_offset_nxt;
            r_cnt_col <= w_cnt_col_nxt;
            r_cnt_row <= w_cnt_row_nxt;
            r_busy    <= w_busy_nxt;
            r_we      <= w_we_nxt;
            r_waddr   <= w_waddr_nxt;
            r_wchar   <= w_wchar_nxt;
            r_wattr   <= w_wattr_nxt;
        end
    end

    assign o_busy       = r_busy;
    assign o_ram_we     = r_we;
    assign o_ram_waddr  = r_waddr;
    assign o_ram_wchar  = r_wchar;
    assign o_ram_wattr  = r_wattr;
    assign o_row_offset = {2'b00, r_offset};

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer: a cursor/offset model queues expected
// RAM writes, a forked monitor pops one per observed RAM_WE.
module tb_text_buffer_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_we = 1'b0;
    logic [2:0]  host_addr = 3'd0;
    logic [7:0]  host_wdata = 8'd0;
    logic        busy;
    logic        ram_we;
    logic [12:0] ram_waddr;
    logic [7:0]  ram_wchar;
    logic [7:0]  ram_wattr;
    logic [7:0]  row_offset;

    text_buffer_writer dut (
        .i_clock_core (clk),
        .i_reset_n    (rst_n),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_busy       (busy),
        .o_ram_we     (ram_we),
        .o_ram_waddr  (ram_waddr),
        .o_ram_wchar  (ram_wchar),
        .o_ram_wattr  (ram_wattr),
        .o_row_offset (row_offset)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  c;
        logic [7:0]  t;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    int  m_col, m_row, m_attr, m_off;
    bit  m_busy;
    int  e_busy, e_off_before, e_off_after;
    int  busy_run = 0;
    bit  prev_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_wr(input int prow, input int col, input int ch, input int at);
        wr_t w;
        w.a = 13'(prow * 128 + col);
        w.c = 8'(ch);
        w.t = 8'(at);
        exp_q.push_back(w);
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_attr = 'h0F; m_off = 0; m_busy = 1'b0;
    endtask

    task automatic m_scroll();
        int prow;
        prow = (m_off + 30) % 64;
        for (int c = 0; c < 80; c++) push_wr(prow, c, 'h20, m_attr);
        e_off_before = m_off;
        m_off = (m_off + 1) % 64;
        e_off_after = m_off;
        e_busy = 81;
        m_busy = 1'b1;
    endtask

    task automatic m_clear();
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 80; c++) push_wr(r, c, 'h20, m_attr);
        e_off_before = m_off;
        m_off = 0; m_col = 0; m_row = 0;
        e_off_after = 0;
        e_busy = 5121;
        m_busy = 1'b1;
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row < 29) m_row++;
        else m_scroll();
    endtask

    task automatic model_apply(input int a, input int d);
        if (m_busy) return;
        case (a)
            0: m_col = (d < 80) ? d : 0;
            1: m_row = (d < 30) ? d : 29;
            2: m_attr = d;
            3: begin
                push_wr((m_row + m_off) % 64, m_col, d, m_attr);
                if (m_col < 79) m_col++;
                else m_newline();
            end
            4: begin
                if (d % 2 == 1) m_clear();
                else if ((d / 2) % 2 == 1) m_newline();
            end
            5: m_off = d % 64;
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic host_write(input int a, input int d);
        bit is_char;
        is_char = (a == 3) && !m_busy;
        model_apply(a, d);
        host_we = 1'b1;
        host_addr = 3'(a);
        host_wdata = 8'(d);
        @(negedge clk);
        host_we = 1'b0;
        if (is_char) chk("char_we_latency", {31'd0, ram_we}, 32'd1);
    endtask

    task automatic wait_idle();
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (busy === 1'b1 && cnt < 6000) begin
            if (row_offset !== 8'(e_off_before)) bad++;
            @(negedge clk);
            cnt++;
        end
        chk("busy_bounded", {31'd0, busy}, 32'd0);
        chk("busy_cycles", busy_run, e_busy);
        chk("offset_hold", bad, 0);
        chk("offset_after", {24'd0, row_offset}, e_off_after);
        chk("queue_drained", exp_q.size(), 0);
        m_busy = 1'b0;
    endtask

    task automatic run_monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy = 1'b0;
                busy_run = 0;
            end else begin
                if (busy) busy_run = prev_busy ? busy_run + 1 : 1;
                prev_busy = busy;
                if (ram_we) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h char 0x%0h attr 0x%0h, expected no write",
                                 ram_waddr, ram_wchar, ram_wattr);
                    end else begin
                        w = exp_q.pop_front();
                        chk("ram_write", {3'd0, ram_waddr, ram_wchar, ram_wattr}, {3'd0, w});
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, ram_we}, 32'd0);
        chk("rst_waddr", {19'd0, ram_waddr}, 32'd0);
        chk("rst_wchar", {24'd0, ram_wchar}, 32'd0);
        chk("rst_wattr", {24'd0, ram_wattr}, 32'd0);
        chk("rst_offset", {24'd0, row_offset}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic cursor write and single-cycle pulse
        host_write(2, 'h1E);
        host_write(0, 5);
        host_write(1, 2);
        host_write(3, 'h41);
        @(negedge clk);
        chk("we_pulse_width", {31'd0, ram_we}, 32'd0);
        host_write(3, 'h44);
        @(negedge clk);

        // Column wrap with back-to-back strobes
        host_write(0, 79);
        host_write(1, 3);
        host_write(3, 'h42);
        host_write(3, 'h43);
        host_write(3, 'h44);
        @(negedge clk);

        // CHAR-triggered scroll at offset 40
        host_write(5, 40);
        host_write(0, 79);
        host_write(1, 29);
        host_write(3, 'h58);
        wait_idle();
        host_write(3, 'h31);
        @(negedge clk);

        // Newline-triggered scroll with offset wrap
        host_write(5, 63);
        host_write(1, 29);
        host_write(4, 'h02);
        wait_idle();
        host_write(3, 'h32);
        @(negedge clk);

        // Full clear with discarded CHAR strobes
        host_write(2, 'h70);
        host_write(4, 'h03);
        host_write(3, 'h99);
        repeat (200) @(negedge clk);
        host_write(3, 'h55);
        wait_idle();
        host_write(3, 'h21);
        @(negedge clk);

        // Reset in the middle of a clear
        host_write(5, 17);
        host_write(4, 'h01);
        repeat (999) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_we", {31'd0, ram_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_offset", {24'd0, row_offset}, 32'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        chk("abort_waddr", {19'd0, ram_waddr}, 32'd0);
        chk("abort_wattr", {24'd0, ram_wattr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        host_write(3, 'h5A);
        @(negedge clk);
        chk("post_reset_queue", exp_q.size(), 0);

        // Randomized register traffic
        for (int i = 0; i < 400; i++) begin
            int a;
            int d;
            a = int'($urandom_range(0, 7));
            case (a)
                0: d = int'($urandom_range(0, 100));
                1: d = int'($urandom_range(0, 40));
                4: d = ($urandom_range(0, 19) == 0) ? 1 :
                       (int'($urandom_range(0, 255)) & 'hFE);
                default: d = int'($urandom_range(0, 255));
            endcase
            host_write(a, d);
            if (m_busy) wait_idle();
        end
        if (m_busy) wait_idle();
        repeat (3) @(negedge clk);
        chk("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
